xbar_arbiter: RTL

Per-output arbitration plane for the stream crossbar, the stateful successor to combinational conflict detection. Each of the M_DATA_COUNT output ports runs its own round-robin arbiter over the S_DATA_COUNT input masters. A winner is locked to an output for a whole packet, up to and including the beat that carries `last`. The block drives the crossbar mux selects, the per-input `ready` and the per-output `valid`, and flags contention per output.

---
 rtl/xbar_arbiter.sv | 126 ++++++++++++
 1 files changed

// File: rtl/xbar_arbiter.sv
// xbar_arbiter: one round-robin arbiter per crossbar output, granting an input for a whole packet.
// Build option XBAR_PACKET_LOCK_EN: hold a grant until the `last` beat; otherwise release on every beat.

module xbar_arbiter #(
   parameter  int S_DATA_COUNT = 2,
   parameter  int M_DATA_COUNT = 3,
   localparam int T_DEST_WIDTH = $clog2(M_DATA_COUNT),
   localparam int SEL_WIDTH    = $clog2(S_DATA_COUNT)
) (
   input  logic                                      clk,
   input  logic                                      rst_n,
   input  logic [S_DATA_COUNT-1:0]                   s_valid_i,
   input  logic [S_DATA_COUNT-1:0]                   s_last_i,
   input  logic [S_DATA_COUNT-1:0][T_DEST_WIDTH-1:0] s_dest_i,
   input  logic [M_DATA_COUNT-1:0]                   m_ready_i,
   output logic [S_DATA_COUNT-1:0]                   s_ready_o,
   output logic [M_DATA_COUNT-1:0]                   m_valid_o,
   output logic [M_DATA_COUNT-1:0][SEL_WIDTH-1:0]    m_sel_o,
   output logic [M_DATA_COUNT-1:0]                   conflict_o,
   output logic [M_DATA_COUNT-1:0]                   busy_o
);

   typedef enum logic {IDLE, LOCKED} state_t;

   logic [M_DATA_COUNT-1:0][S_DATA_COUNT-1:0] lane_rdy;

`ifndef XBAR_PACKET_LOCK_EN
   logic unused_last;
   assign unused_last = ^s_last_i;
`endif

   for (genvar j = 0; j < M_DATA_COUNT; j++) begin : g_out
      state_t                  state_q, state_d;
      logic [SEL_WIDTH-1:0]    owner_q, owner_d, ptr_q, ptr_d, winner, owner_inc;
      logic                    conflict_q, conflict_d, found, locked, hs, rel;
      logic [S_DATA_COUNT-1:0] req, rdy;

      // Out-of-range dests never match any j, so they raise no request anywhere.
      always_comb begin
         req = '0;
         for (int i = 0; i < S_DATA_COUNT; i++)
            req[i] = s_valid_i[i] && (s_dest_i[i] == T_DEST_WIDTH'(j));
      end

      // Round-robin: first requester at or above ptr, else the first one below it.
      always_comb begin
         winner = '0;
         found  = 1'b0;
         for (int i = 0; i < S_DATA_COUNT; i++)
            if (!found && req[i] && SEL_WIDTH'(i) >= ptr_q) begin
               winner = SEL_WIDTH'(i);
               found  = 1'b1;
            end
         for (int i = 0; i < S_DATA_COUNT; i++)
            if (!found && req[i]) begin
               winner = SEL_WIDTH'(i);
               found  = 1'b1;
            end
      end

      assign locked    = (state_q == LOCKED);
      assign owner_inc = (owner_q == SEL_WIDTH'(S_DATA_COUNT - 1)) ? '0 : owner_q + SEL_WIDTH'(1);
      assign hs        = locked && s_valid_i[owner_q] && m_ready_i[j];
`ifdef XBAR_PACKET_LOCK_EN
      assign rel       = hs && s_last_i[owner_q];
`else
      assign rel       = hs;
`endif

      always_comb begin
         state_d    = state_q;
         owner_d    = owner_q;
         ptr_d      = ptr_q;
         conflict_d = 1'b0;
         case (state_q)
            IDLE: begin
               conflict_d = ($countones(req) > 1);
               if (|req) begin
                  owner_d = winner;
                  state_d = LOCKED;
               end
            end
            LOCKED: begin
               if (rel) begin
                  state_d = IDLE;
                  ptr_d   = owner_inc;
               end
            end
            default: state_d = IDLE;
         endcase
      end

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            state_q    <= IDLE;
            owner_q    <= '0;
            ptr_q      <= '0;
            conflict_q <= 1'b0;
         end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            ptr_q      <= ptr_d;
            conflict_q <= conflict_d;
         end
      end

      // Ready depends only on registered ownership, never on the dest of other inputs.
      always_comb begin
         rdy = '0;
         if (locked) rdy[owner_q] = m_ready_i[j];
      end

      assign lane_rdy[j]   = rdy;
      assign busy_o[j]     = locked;
      assign m_valid_o[j]  = locked && s_valid_i[owner_q];
      assign m_sel_o[j]    = owner_q;
      assign conflict_o[j] = conflict_q;
   end

   always_comb begin
      s_ready_o = '0;
      for (int j = 0; j < M_DATA_COUNT; j++)
         s_ready_o = s_ready_o | lane_rdy[j];
   end

endmodule
